// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, keyboard command bytes
// and the frame parity helper used by both host and decoder paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_ACK       = 3'd6,
    ST_WAIT_IDLE = 3'd7
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  localparam int PS2_TO_W = 22;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a falling-edge
// detector on the synchronized clock. Resets to an idle (high) bus.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign o_clk_sync  = r_clk_sync[1];
  assign o_data_sync = r_data_sync[1];
  assign o_clk_fall  = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, device ACK check, with a per-state timeout.
//
// state      | meaning
// IDLE       | ready for a byte, bus released
// INHIBIT    | clock held low; data pulled low in the final cycle
// REQ        | start bit driven, waiting for the device's first clock
// DATA       | shifting out bits 0..7 on device falling edges
// PARITY     | parity bit driven
// STOP       | data released (stop=1); next edge samples device ACK
// ACK        | waiting for the device to release clock and data
// WAIT_IDLE  | single cycle reporting done or error
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0]    INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_TO_W-1:0] TO_LAST  = PS2_TO_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e       r_state, w_state_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic                r_parity, w_parity_nxt;
  logic [2:0]          r_bit_cnt, w_bit_nxt;
  logic [INH_W-1:0]    r_inh_cnt, w_inh_nxt;
  logic                r_err, w_err_nxt;
  logic [PS2_TO_W-1:0] r_to_cnt;
  logic                w_clk_sync, w_data_sync, w_clk_fall;
  logic                w_waiting;

  ps2_edge_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_ps2_clk   (ps2_clk_in),
    .i_ps2_data  (ps2_data_in),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_clk_fall  (w_clk_fall)
  );

  assign w_waiting = (r_state == ST_REQ) || (r_state == ST_DATA) ||
                     (r_state == ST_PARITY) || (r_state == ST_STOP) ||
                     (r_state == ST_ACK);
  assign tx_ready  = (r_state == ST_IDLE);
  assign busy      = ~tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_inh_cnt <= w_inh_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Any progress (state change or device clock edge) restarts the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_to_cnt <= '0;
    else if ((w_state_nxt != r_state) || w_clk_fall || !w_waiting)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_bit_nxt    = r_bit_cnt;
    w_inh_nxt    = r_inh_cnt;
    w_err_nxt    = r_err;
    ps2_clk_oe   = 1'b0;
    ps2_data_oe  = 1'b0;
    tx_done      = 1'b0;
    tx_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_err_nxt = 1'b0;
        if (tx_valid) begin
          w_shift_nxt  = tx_data;
          w_parity_nxt = odd_parity(tx_data);
          w_inh_nxt    = INH_LOAD;
          w_state_nxt  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (r_inh_cnt == '0);
        if (r_inh_cnt == '0) w_state_nxt = ST_REQ;
        else                 w_inh_nxt   = r_inh_cnt - 1'b1;
      end
      ST_REQ: begin
        ps2_data_oe = 1'b1;
        if (w_clk_fall) begin
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        ps2_data_oe = ~r_shift[r_bit_cnt];
        if (w_clk_fall) begin
          w_bit_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        ps2_data_oe = ~r_parity;
        if (w_clk_fall) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_clk_fall) begin
          if (!w_data_sync) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
          end
        end
      end
      ST_ACK: begin
        if (w_clk_sync && w_data_sync) w_state_nxt = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        tx_done     = ~r_err;
        tx_err      = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_waiting && (r_to_cnt == TO_LAST)) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      tx_err      = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain bus with a behavioural PS/2
// device that clocks frames in, ACKs (or not) and a frame reference model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 500;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       w_clk_line, w_data_line;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, frame_cnt = 0;
  int inh_run = 0, inh_drun = 0, inh_len = 0, inh_dcnt = 0;
  logic inh_last_d = 1'b0, inh_dlast = 1'b0;

  assign w_clk_line  = dev_clk & ~ps2_clk_oe;
  assign w_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (w_clk_line),
    .ps2_data_in (w_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse counters and inhibit-phase measurement, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (ps2_clk_oe) begin
      inh_run++;
      if (ps2_data_oe) inh_drun++;
      inh_last_d = ps2_data_oe;
    end else if (inh_run != 0) begin
      inh_len   = inh_run;
      inh_dcnt  = inh_drun;
      inh_dlast = inh_last_d;
      frame_cnt++;
      inh_run   = 0;
      inh_drun  = 0;
    end
  end

  // Reference frame as seen on the wire: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_start(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic dev_receive(input bit ack, input int abort_falls,
                             output logic [10:0] bits, output bit ok);
    ok   = 1'b0;
    bits = '0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy && !ps2_clk_oe && !w_data_line) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    bits[0] = w_data_line;
    repeat (5) step();
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      if (i == abort_falls) begin
        repeat (10) step();
        return;
      end
      repeat (HALF) step();
      dev_clk = 1'b1;
      bits[i] = w_data_line;
      repeat (HALF) step();
    end
    if (ack) dev_data = 1'b0;
    repeat (5) step();
    dev_clk = 1'b0;
    repeat (HALF) step();
    dev_clk = 1'b1;
    repeat (5) step();
    dev_data = 1'b1;
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 ||
        ps2_data_oe !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b busy=%b coe=%b doe=%b done=%b err=%b want 1 0 0 0 0 0",
               tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err);
    end
    rst = 1'b1;
    repeat (3) step();
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || done_cnt != 0 || err_cnt != 0) begin
      bad++;
      $display("FAIL post_reset_idle got ready=%b busy=%b done=%0d err=%0d want 1 0 0 0",
               tx_ready, busy, done_cnt, err_cnt);
    end
  endtask

  task automatic test_frame(input logic [7:0] d, input string nm);
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got=%b want=1", nm, tx_ready);
    end
    send_start(d);
    dev_receive(1'b1, 0, bits, ok);
    wait_pulse(d0, e0);
    total++;
    if (!ok || bits !== frame_of(d)) begin
      bad++;
      $display("FAIL %s wire_bits data=%h got=%b want=%b ok=%0d", nm, d, bits, frame_of(d), ok);
    end
    total++;
    if (inh_len != INH || inh_dcnt != 1 || inh_dlast !== 1'b1) begin
      bad++;
      $display("FAIL %s inhibit got len=%0d data_cycles=%0d data_last=%b want %0d 1 1",
               nm, inh_len, inh_dcnt, inh_dlast, INH);
    end
    total++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      bad++;
      $display("FAIL %s pulses got done=%0d err=%0d want done=1 err=0", nm, done_cnt - d0, err_cnt - e0);
    end
    total++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      bad++;
      $display("FAIL %s end_idle got ready=%b coe=%b doe=%b want 1 0 0", nm, tx_ready, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_timeout();
    int d0, e0, n;
    bit found;
    d0 = done_cnt;
    e0 = err_cnt;
    found = 1'b0;
    n = 0;
    send_start(8'($urandom));
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy && !ps2_clk_oe && ps2_data_oe) begin
        found = 1'b1;
        break;
      end
    end
    n = 1;
    while (found && !tx_err && n < 800) begin
      step();
      n++;
    end
    total++;
    if (!found || tx_err !== 1'b1 || n < TMO - 1 || n > TMO + 1) begin
      bad++;
      $display("FAIL timeout_latency got found=%0d err=%b cycles=%0d want ~%0d", found, tx_err, n, TMO);
    end
    total++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL timeout_release got coe=%b doe=%b done=%b want 0 0 0", ps2_clk_oe, ps2_data_oe, tx_done);
    end
    step();
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || done_cnt != d0 || err_cnt - e0 != 1) begin
      bad++;
      $display("FAIL timeout_after got ready=%b busy=%b done=%0d err=%0d want 1 0 0 1",
               tx_ready, busy, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    logic [7:0] d;
    bit ok;
    int d0, e0;
    d = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    send_start(d);
    dev_receive(1'b0, 0, bits, ok);
    wait_pulse(d0, e0);
    total++;
    if (!ok || bits !== frame_of(d)) begin
      bad++;
      $display("FAIL nack wire_bits got=%b want=%b", bits, frame_of(d));
    end
    total++;
    if (err_cnt - e0 != 1 || done_cnt != d0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL nack pulses got err=%0d done=%0d ready=%b want 1 0 1",
               err_cnt - e0, done_cnt - d0, tx_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits, exp;
    logic [7:0] d;
    bit ok;
    int d0, e0;
    d = 8'($urandom) & 8'hEF;
    exp = frame_of(d);
    d0 = done_cnt;
    e0 = err_cnt;
    send_start(d);
    dev_receive(1'b1, 5, bits, ok);
    total++;
    if (!ok || bits[4:0] !== exp[4:0] || ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midframe_state got bits=%b want=%b doe=%b busy=%b", bits[4:0], exp[4:0], ps2_data_oe, busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_release got coe=%b doe=%b busy=%b ready=%b want 0 0 0 1",
               ps2_clk_oe, ps2_data_oe, busy, tx_ready);
    end
    step();
    dev_clk = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if (done_cnt != d0 || err_cnt != e0) begin
      bad++;
      $display("FAIL reset_no_pulse got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    bit ok;
    int d0, e0, f0;
    d0 = done_cnt;
    e0 = err_cnt;
    f0 = frame_cnt;
    tx_data  = PS2_CMD_RESET;
    tx_valid = 1'b1;
    step();
    tx_data = 8'($urandom);
    dev_receive(1'b1, 0, bits, ok);
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      step();
    end
    tx_valid = 1'b0;
    repeat (60) step();
    total++;
    if (!ok || bits !== frame_of(PS2_CMD_RESET)) begin
      bad++;
      $display("FAIL held_valid wire_bits got=%b want=%b", bits, frame_of(PS2_CMD_RESET));
    end
    total++;
    if (done_cnt - d0 != 1 || err_cnt != e0 || frame_cnt - f0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL held_valid frames got done=%0d err=%0d frames=%0d busy=%b want 1 0 1 0",
               done_cnt - d0, err_cnt - e0, frame_cnt - f0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_frame(PS2_CMD_SET_LEDS, "set_leds");
    test_frame(8'h00, "zero_byte");
    test_frame(8'h01, "one_byte");
    for (int i = 0; i < 4; i++) test_frame(8'($urandom), "random_byte");
    test_timeout();
    test_nack();
    test_reset_mid();
    test_back_to_back();
    test_frame(8'($urandom), "after_all");
    total++;
    if (both_cnt != 0) begin
      bad++;
      $display("FAIL done_err_overlap got=%0d want=0", both_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
